clk_div_levels: RTL and testbench
=================================

CLK_DIV_LEVELS -- requirements
Module: clk_div_levels

Interface
REQ-001 SHALL have parameter DIV1, default 25000000, meaning the CL1 half-period in clock cycles (1 Hz at 50 MHz).
REQ-002 SHALL have parameter DIV2, default 12500000, meaning the CL2 half-period in clock cycles (2 Hz).
REQ-003 SHALL have parameter DIV3, default 6250000, meaning the CL3 half-period in clock cycles (4 Hz).
REQ-004 SHALL have parameter DIV4, default 3125000, meaning the CL4 half-period in clock cycles (8 Hz).
REQ-005 SHALL have port CLOCK  input  1  system clock; all state updates on its rising edge.
REQ-006 SHALL have port RESET_N  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port EN  input  1  count enable; low freezes all counters and outputs.
REQ-008 SHALL have port SYNC  input  1  synchronous restart of all four dividers.
REQ-009 SHALL have ports CL1, CL2, CL3, CL4  output  1 each  registered square-wave rate clocks feeding the level-select mux.
REQ-010 SHALL have ports P1, P2, P3, P4  output  1 each  one-cycle rise strobes, present only per REQ-024.

Function
REQ-011 SHALL keep one independent counter per output, each sized to ceil(log2(DIVi)) bits, minimum 1 bit.
REQ-012 SHALL, on a clock edge with EN=1 and SYNC=0, increment cnt_i when cnt_i < DIVi-1.
REQ-013 SHALL, on such an edge with cnt_i == DIVi-1, set cnt_i to 0 and invert CLi, giving a CLi period of exactly 2*DIVi cycles at 50% duty.
REQ-014 SHALL, when DIVi == 1, toggle CLi on every enabled edge (period 2 cycles).
REQ-015 SHALL, on an edge with EN=0 and SYNC=0, hold all counters and CL outputs unchanged.
REQ-016 SHALL, on an edge with SYNC=1, clear all counters to 0 and drive all CL outputs to 0, regardless of EN; SYNC has priority over EN.
REQ-017 SHALL produce the first CLi rising edge exactly DIVi enabled cycles after reset release or SYNC deassertion, keeping all four outputs phase-aligned at common rising edges.
REQ-018 SHALL never let a counter exceed DIVi-1 (no wrap through 2^width).
REQ-019 SHALL drive all CL outputs directly from flops, with no combinational path from inputs to outputs.
REQ-020 SHALL fail elaboration if any DIVi is less than 1.

Reset
REQ-021 SHALL, while RESET_N=0, immediately force all counters to 0 and all CL (and P) outputs to 0, independent of CLOCK.
REQ-022 SHALL, on RESET_N deassertion mid-period, restart counting from 0 on the first rising edge with EN=1; any partial period in progress is discarded.
REQ-023 SHALL define reset values as: cnt_i=0, CL1..CL4=0, P1..P4=0.

Configuration
REQ-024 SHALL, when macro CLK_DIV_LEVELS_PULSE_EN is defined, include P1..P4. Pi is a registered strobe that is 1 for exactly the one cycle in which CLi first reads 1 after a 0->1 toggle, and 0 otherwise, including under EN=0 and SYNC=1.
REQ-025 SHALL, when CLK_DIV_LEVELS_PULSE_EN is undefined, omit ports P1..P4 and their logic entirely; CL behaviour is identical in both builds.

Verification (DIV1=2, DIV2=3, DIV3=4, DIV4=1)
REQ-026 SHALL cover: reset release with EN=1 -> CL4 toggles every cycle; CL1 rises after 2 cycles with period 4; CL2 rises after 3 with period 6; CL3 rises after 4 with period 8.
REQ-027 SHALL cover: EN dropped for 5 cycles while CL2's cnt=1 -> CL2 and cnt frozen 5 cycles; CL2 toggles 2 enabled cycles after EN returns.
REQ-028 SHALL cover: SYNC=1 with EN=0 while CL1=1 -> next edge all CL=0 and counters=0; after SYNC drops, CL1 rises after 2 enabled cycles.
REQ-029 SHALL cover: RESET_N pulsed low between clock edges -> all outputs 0 before the next edge; counting restarts from 0.
REQ-030 SHALL cover: with CLK_DIV_LEVELS_PULSE_EN, 16 enabled cycles -> P1 high 4 times and P3 high 2 times, each for 1 cycle and coincident with the first high cycle of CL1/CL3; without the macro the build has no P ports.

Source files
------------

// File: rtl/clk_div_levels.sv
// rtl/clk_div_levels.sv - four independent square-wave rate dividers feeding the level-select mux
// Optional build macro CLK_DIV_LEVELS_PULSE_EN adds one-cycle rise strobes P1..P4.
module clk_div_levels #(
  parameter int DIV1 = 25000000,
  parameter int DIV2 = 12500000,
  parameter int DIV3 = 6250000,
  parameter int DIV4 = 3125000
) (
  input  logic CLOCK,
  input  logic RESET_N,
  input  logic EN,
  input  logic SYNC,
  output logic CL1,
  output logic CL2,
  output logic CL3,
  output logic CL4
`ifdef CLK_DIV_LEVELS_PULSE_EN
  ,
  output logic P1,
  output logic P2,
  output logic P3,
  output logic P4
`endif
);

  localparam int DIV_ARR [4] = '{DIV1, DIV2, DIV3, DIV4};

  logic [3:0] cl_q;
`ifdef CLK_DIV_LEVELS_PULSE_EN
  logic [3:0] rise_q;
`endif

  for (genvar g = 0; g < 4; g++) begin : g_div
    localparam int D = DIV_ARR[g];
    // A divider of 1 still needs a 1-bit counter that simply sits at 0.
    localparam int W = (D > 1) ? $clog2(D) : 1;
    localparam logic [W-1:0] LAST = W'(D - 1);

    if (D < 1) begin : g_bad_div
      $error("clk_div_levels: every DIVi must be at least 1");
    end

    logic [W-1:0] cnt;

    // Half-period counter: toggles the rate clock on the terminal count, SYNC beats EN.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
        cnt     <= '0;
        cl_q[g] <= 1'b0;
`ifdef CLK_DIV_LEVELS_PULSE_EN
        rise_q[g] <= 1'b0;
`endif
      end else if (SYNC) begin
        cnt     <= '0;
        cl_q[g] <= 1'b0;
`ifdef CLK_DIV_LEVELS_PULSE_EN
        rise_q[g] <= 1'b0;
`endif
      end else if (EN) begin
        if (cnt == LAST) begin
          cnt     <= '0;
          cl_q[g] <= ~cl_q[g];
`ifdef CLK_DIV_LEVELS_PULSE_EN
          // Strobe lands in the same cycle the rate clock first reads high.
          rise_q[g] <= ~cl_q[g];
`endif
        end else begin
          cnt <= cnt + W'(1);
`ifdef CLK_DIV_LEVELS_PULSE_EN
          rise_q[g] <= 1'b0;
`endif
        end
      end else begin
`ifdef CLK_DIV_LEVELS_PULSE_EN
        rise_q[g] <= 1'b0;
`endif
      end
    end
  end

  assign CL1 = cl_q[0];
  assign CL2 = cl_q[1];
  assign CL3 = cl_q[2];
  assign CL4 = cl_q[3];

`ifdef CLK_DIV_LEVELS_PULSE_EN
  assign P1 = rise_q[0];
  assign P2 = rise_q[1];
  assign P3 = rise_q[2];
  assign P4 = rise_q[3];
`endif

endmodule

// File: tb/tb_clk_div_levels.sv
// tb/tb_clk_div_levels.sv - self-checking bench for clk_div_levels (DIV1=2, DIV2=3, DIV3=4, DIV4=1)
module tb_clk_div_levels;

  logic CLOCK;
  logic RESET_N;
  logic EN;
  logic SYNC;
  logic CL1, CL2, CL3, CL4;
`ifdef CLK_DIV_LEVELS_PULSE_EN
  logic P1, P2, P3, P4;
`endif

  clk_div_levels #(
    .DIV1(2),
    .DIV2(3),
    .DIV3(4),
    .DIV4(1)
  ) dut (
    .CLOCK  (CLOCK),
    .RESET_N(RESET_N),
    .EN     (EN),
    .SYNC   (SYNC),
    .CL1    (CL1),
    .CL2    (CL2),
    .CL3    (CL3),
    .CL4    (CL4)
`ifdef CLK_DIV_LEVELS_PULSE_EN
    ,
    .P1     (P1),
    .P2     (P2),
    .P3     (P3),
    .P4     (P4)
`endif
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  // Reference model: every divider sees the same EN/SYNC, so the whole state
  // is the number of enabled cycles since the last restart.
  int divs [4] = '{2, 3, 4, 1};
  int elapsed;
  bit last_step;
  int errors;
  int checks;

  function automatic logic [3:0] exp_cl();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = ((elapsed / divs[i]) % 2) == 1;
    return v;
  endfunction

  function automatic logic [3:0] exp_p();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = last_step && ((elapsed % (2 * divs[i])) == divs[i]);
    return v;
  endfunction

  task automatic check(input string tag);
    logic [3:0] obs;
    logic [3:0] expv;
    obs  = {CL4, CL3, CL2, CL1};
    expv = exp_cl();
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cl: observed=%b expected=%b elapsed=%0d", tag, obs, expv, elapsed);
    end
`ifdef CLK_DIV_LEVELS_PULSE_EN
    obs  = {P4, P3, P2, P1};
    expv = exp_p();
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s p: observed=%b expected=%b elapsed=%0d", tag, obs, expv, elapsed);
    end
`endif
  endtask

  task automatic tick(input logic en, input logic sy, input string tag);
    EN   = en;
    SYNC = sy;
    @(posedge CLOCK);
    if (sy) begin
      elapsed   = 0;
      last_step = 0;
    end else if (en) begin
      elapsed++;
      last_step = 1;
    end else begin
      last_step = 0;
    end
    #1;
    check(tag);
  endtask

  // Called just after an edge: pulse reset low between edges and check with no clock.
  task automatic async_reset(input string tag);
    #2 RESET_N = 1'b0;
    #1;
    elapsed   = 0;
    last_step = 0;
    check(tag);
    #2 RESET_N = 1'b1;
  endtask

  int p1_cnt;
  int p3_cnt;

  initial begin
    errors    = 0;
    checks    = 0;
    elapsed   = 0;
    last_step = 0;
    RESET_N   = 1'b0;
    EN        = 1'b0;
    SYNC      = 1'b0;

    #2;
    check("reset_state");
    @(posedge CLOCK);
    #1;
    check("reset_held_edge");
    #2 RESET_N = 1'b1;

    // Free run after reset release
    for (int i = 0; i < 16; i++) tick(1'b1, 1'b0, "free_run");

    // Freeze with CL2 counter at 1, then resume
    for (int i = 0; i < 6 && (elapsed % 3) != 1; i++) tick(1'b1, 1'b0, "align_cl2");
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, "en_freeze");
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, "en_resume");

    // SYNC while EN=0 and CL1 high
    for (int i = 0; i < 6 && !exp_cl()[0]; i++) tick(1'b1, 1'b0, "align_cl1");
    tick(1'b0, 1'b1, "sync_en_low");
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, "after_sync");

    // Reset pulse between edges mid-period
    tick(1'b1, 1'b0, "pre_async");
    async_reset("async_reset");
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, "after_async");

    // Randomised EN / SYNC / reset mix
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) async_reset("rand_reset");
      else tick(($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0), "random");
    end

`ifdef CLK_DIV_LEVELS_PULSE_EN
    // Strobe counts over 16 enabled cycles from a fresh restart
    tick(1'b0, 1'b1, "pulse_sync");
    p1_cnt = 0;
    p3_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, 1'b0, "pulse_run");
      if (P1 === 1'b1) p1_cnt++;
      if (P3 === 1'b1) p3_cnt++;
    end
    checks++;
    assert (p1_cnt == 4) else begin
      errors++;
      $error("FAIL p1_count: observed=%0d expected=4", p1_cnt);
    end
    checks++;
    assert (p3_cnt == 2) else begin
      errors++;
      $error("FAIL p3_count: observed=%0d expected=2", p3_cnt);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
